sequencer: RTL and testbench

- Instruction sequencer sitting directly upstream of the cell-array multiprocessor.
- Fetches 16-bit words from an external synchronous program ROM and resolves control flow (jump, divergence-conditional jump, call/return, halt) locally.
- Broadcasts data-path instructions to the array with a one-cycle execution_enable pulse, plus the matching next_program_counter/next_stack_pointer.
- Consumes the array's diverge_consensus for conditional branches.

---
 rtl/sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequencer.sv
// Instruction sequencer: fetches from a synchronous program ROM and resolves control flow.
// Optional SEQUENCER_ISSUE_COUNT_EN adds a saturating issue_count output.
module sequencer #(
    parameter int PC_LENGTH = 12,
    parameter int SP_LENGTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [PC_LENGTH-1:0] prog_addr,
    input  logic [15:0]          prog_data,
    output logic [15:0]          instruction,
    output logic                 execution_enable,
    output logic [PC_LENGTH-1:0] next_program_counter,
    output logic [SP_LENGTH-1:0] next_stack_pointer,
    input  logic                 diverge_consensus,
    output logic                 busy,
    output logic                 halted,
    output logic                 error
`ifdef SEQUENCER_ISSUE_COUNT_EN
    ,
    output logic [31:0]          issue_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_FETCH_IMM,
        S_IMM,
        S_HALTED
    } state_t;

    typedef enum logic [1:0] {
        OP_JMP,
        OP_JDIV,
        OP_CALL
    } op_t;

    state_t state, state_d;
    op_t    op, op_d;

    logic [PC_LENGTH-1:0] pc, pc_d;
    logic [SP_LENGTH-1:0] sp, sp_d;
    logic [PC_LENGTH-1:0] addr_d;
    logic [15:0]          instr_d;
    logic                 ee_d;
    logic [PC_LENGTH-1:0] npc_d;
    logic [SP_LENGTH-1:0] nsp_d;
    logic                 err_d;

    logic [PC_LENGTH-1:0] stack [2**SP_LENGTH];
    logic                 push_en;
    logic [PC_LENGTH-1:0] pc_inc;
    logic [SP_LENGTH-1:0] sp_dec;
    logic [PC_LENGTH-1:0] target;
    logic [PC_LENGTH-1:0] new_pc;
    logic                 start_ok;

    assign pc_inc   = pc + PC_LENGTH'(1);
    assign sp_dec   = sp - SP_LENGTH'(1);
    assign target   = prog_data[PC_LENGTH-1:0];
    assign start_ok = start && (state == S_IDLE || state == S_HALTED);
    assign busy     = (state != S_IDLE) && (state != S_HALTED);
    assign halted   = (state == S_HALTED);

    always_comb begin
        state_d = state;
        op_d    = op;
        pc_d    = pc;
        sp_d    = sp;
        addr_d  = prog_addr;
        instr_d = instruction;
        ee_d    = 1'b0;
        npc_d   = next_program_counter;
        nsp_d   = next_stack_pointer;
        err_d   = error;
        push_en = 1'b0;
        new_pc  = target;
        unique case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    sp_d    = '0;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (prog_data[15:12] != 4'hF) begin
                    instr_d = prog_data;
                    ee_d    = 1'b1;
                    npc_d   = pc_inc;
                    nsp_d   = sp;
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    state_d = S_FETCH;
                end else begin
                    case (prog_data[11:8])
                        4'h0: state_d = S_HALTED;
                        4'h1, 4'h2, 4'h3: begin
                            op_d    = op_t'(prog_data[9:8] - 2'd1);
                            pc_d    = pc_inc;
                            addr_d  = pc_inc;
                            state_d = S_FETCH_IMM;
                        end
                        4'h4: begin
                            if (sp == '0) begin
                                err_d   = 1'b1;
                                state_d = S_HALTED;
                            end else begin
                                sp_d    = sp_dec;
                                pc_d    = stack[sp_dec];
                                addr_d  = stack[sp_dec];
                                state_d = S_FETCH;
                            end
                        end
                        default: begin
                            pc_d    = pc_inc;
                            addr_d  = pc_inc;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end
            S_FETCH_IMM: state_d = S_IMM;
            S_IMM: begin
                state_d = S_FETCH;
                unique case (op)
                    OP_JMP:  new_pc = target;
                    OP_JDIV: new_pc = diverge_consensus ? target : pc_inc;
                    default: begin
                        // Top stack entry stays unused as an overflow guard
                        if (sp == {SP_LENGTH{1'b1}}) begin
                            err_d   = 1'b1;
                            state_d = S_HALTED;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp + SP_LENGTH'(1);
                        end
                    end
                endcase
                if (state_d == S_FETCH) begin
                    pc_d   = new_pc;
                    addr_d = new_pc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= S_IDLE;
            op                   <= OP_JMP;
            pc                   <= '0;
            sp                   <= '0;
            prog_addr            <= '0;
            instruction          <= '0;
            execution_enable     <= 1'b0;
            next_program_counter <= '0;
            next_stack_pointer   <= '0;
            error                <= 1'b0;
        end else begin
            state                <= state_d;
            op                   <= op_d;
            pc                   <= pc_d;
            sp                   <= sp_d;
            prog_addr            <= addr_d;
            instruction          <= instr_d;
            execution_enable     <= ee_d;
            next_program_counter <= npc_d;
            next_stack_pointer   <= nsp_d;
            error                <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[sp] <= pc_inc;
        end
    end

`ifdef SEQUENCER_ISSUE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count <= '0;
        end else if (start_ok) begin
            issue_count <= '0;
        end else if (execution_enable && issue_count != 32'hFFFF_FFFF) begin
            issue_count <= issue_count + 32'd1;
        end
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for sequencer: directed programs plus random programs
// compared against an instruction-level interpreter of the ISA.
module tb_sequencer;
    localparam int PCL = 12;
    localparam int SPL = 5;

    typedef struct packed {
        logic [15:0]    ins;
        logic [PCL-1:0] npc;
        logic [SPL-1:0] nsp;
    } pulse_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           dc = 1'b0;
    logic [PCL-1:0] prog_addr;
    logic [15:0]    prog_data = 16'h0;
    logic [15:0]    instruction;
    logic           execution_enable;
    logic [PCL-1:0] next_program_counter;
    logic [SPL-1:0] next_stack_pointer;
    logic           busy;
    logic           halted;
    logic           error;
`ifdef SEQUENCER_ISSUE_COUNT_EN
    logic [31:0]    issue_count;
`endif

    logic [15:0] rom [4096];
    pulse_t      obs[$];
    pulse_t      expq[$];
    int          n_checks = 0;
    int          n_fail = 0;

    sequencer #(.PC_LENGTH(PCL), .SP_LENGTH(SPL)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .instruction(instruction),
        .execution_enable(execution_enable),
        .next_program_counter(next_program_counter),
        .next_stack_pointer(next_stack_pointer),
        .diverge_consensus(dc),
        .busy(busy),
        .halted(halted),
        .error(error)
`ifdef SEQUENCER_ISSUE_COUNT_EN
        ,
        .issue_count(issue_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) prog_data <= rom[prog_addr];

    always @(negedge clk) begin
        if (!rst && execution_enable)
            obs.push_back({instruction, next_program_counter, next_stack_pointer});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 16'h0;
    endtask

    // Instruction-level interpreter; returns 1 if the program halts within the step budget
    function automatic bit model(input bit d, output bit err);
        int pc = 0;
        int sp = 0;
        int t;
        int stk [32];
        logic [15:0] w;
        expq.delete();
        err = 1'b0;
        for (int step = 0; step < 500; step++) begin
            w = rom[pc];
            if (w[15:12] != 4'hF) begin
                expq.push_back({w, PCL'((pc + 1) % 4096), SPL'(sp)});
                pc = (pc + 1) % 4096;
            end else begin
                case (int'(w[11:8]))
                    0: return 1'b1;
                    1, 2, 3: begin
                        pc = (pc + 1) % 4096;
                        t = int'(rom[pc][11:0]);
                        if (w[11:8] == 4'h1) pc = t;
                        else if (w[11:8] == 4'h2) pc = d ? t : (pc + 1) % 4096;
                        else begin
                            if (sp == 31) begin
                                err = 1'b1;
                                return 1'b1;
                            end
                            stk[sp] = (pc + 1) % 4096;
                            sp++;
                            pc = t;
                        end
                    end
                    4: begin
                        if (sp == 0) begin
                            err = 1'b1;
                            return 1'b1;
                        end
                        sp--;
                        pc = stk[sp];
                    end
                    default: pc = (pc + 1) % 4096;
                endcase
            end
        end
        return 1'b0;
    endfunction

    task automatic run(input string tag, input bit d);
        bit err_m;
        bit ok;
        int cyc;
        int n;
        ok = model(d, err_m);
        obs.delete();
        dc = d;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " halted"}, 64'(halted), 64'(1));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " error"}, 64'(error), 64'(err_m));
        check({tag, " npulse"}, 64'(obs.size()), 64'(expq.size()));
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++)
            check({tag, " pulse"}, 64'(obs[i]), 64'(expq[i]));
`ifdef SEQUENCER_ISSUE_COUNT_EN
        check({tag, " issue_count"}, 64'(issue_count), 64'(expq.size()));
`endif
    endtask

    function automatic logic [15:0] rand_word();
        if ($urandom_range(0, 9) < 6)
            return {4'($urandom_range(0, 14)), 7'($urandom), 5'($urandom)};
        return {4'hF, 4'($urandom_range(0, 5)), 3'b0, 5'($urandom)};
    endfunction

    initial begin
        bit e;
        bit ok;
        clear_rom();
        repeat (3) @(negedge clk);
        check("rst prog_addr", 64'(prog_addr), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst halted", 64'(halted), 64'(0));
        check("rst ee", 64'(execution_enable), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        rom[0] = 16'h1234; rom[1] = 16'h0042; rom[2] = 16'hF000;
        run("t1", 1'b0);
        if (obs.size() == 2) begin
            check("t1 p0", 64'(obs[0]), 64'({16'h1234, 12'd1, 5'd0}));
            check("t1 p1", 64'(obs[1]), 64'({16'h0042, 12'd2, 5'd0}));
        end

        clear_rom();
        rom[0] = 16'hF200; rom[1] = 16'h0010; rom[2] = 16'hF000;
        rom[16] = 16'h1111; rom[17] = 16'hF000;
        run("jdiv1", 1'b1);
        check("jdiv1 n", 64'(obs.size()), 64'(1));
        run("jdiv0", 1'b0);
        check("jdiv0 n", 64'(obs.size()), 64'(0));

        clear_rom();
        rom[0] = 16'hF300; rom[1] = 16'h0020; rom[2] = 16'h2222; rom[3] = 16'hF000;
        rom[32] = 16'h3333; rom[33] = 16'hF400;
        run("call", 1'b0);
        if (obs.size() == 2) begin
            check("call p0", 64'(obs[0]), 64'({16'h3333, 12'd33, 5'd1}));
            check("call p1", 64'(obs[1]), 64'({16'h2222, 12'd3, 5'd0}));
        end

        clear_rom();
        rom[0] = 16'hF400;
        run("ret0", 1'b0);
        check("ret0 err", 64'(error), 64'(1));

        clear_rom();
        rom[0] = 16'hF300; rom[1] = 16'h0000;
        run("callloop", 1'b0);
        check("callloop err", 64'(error), 64'(1));

        clear_rom();
        rom[0] = 16'hF100; rom[1] = 16'h0005; rom[5] = 16'hABCD; rom[6] = 16'hF000;
        run("jmp", 1'b0);
        check("jmp p0", 64'(obs.size() > 0 ? obs[0] : '0), 64'({16'hABCD, 12'd6, 5'd0}));

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("arst prog_addr", 64'(prog_addr), 64'(0));
        check("arst instr", 64'(instruction), 64'(0));
        check("arst npc", 64'(next_program_counter), 64'(0));
        check("arst nsp", 64'(next_stack_pointer), 64'(0));
        check("arst busy", 64'(busy), 64'(0));
        check("arst halted", 64'(halted), 64'(0));
        check("arst error", 64'(error), 64'(0));
        @(negedge clk) rst = 1'b0;
        run("restart", 1'b0);

        for (int r = 0; r < 20; r++) begin
            ok = 1'b0;
            for (int tr = 0; tr < 50 && !ok; tr++) begin
                clear_rom();
                for (int a = 0; a < 31; a++) rom[a] = rand_word();
                rom[31] = 16'hF000;
                ok = model(1'b0, e) && model(1'b1, e);
            end
            if (ok) run("rand", 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
